// File: rtl/av2_coeff_encoder.sv
// ---------------------------------------------------------------------------
// av2_coeff_encoder
//
// Buffers one transform block of quantized coefficients in scan order, then
// streams them out as symbols for the entropy encoder. The symbols are the
// values at positions 0..last_nz, followed by the EOB symbol 16'hFFFF unless
// the last nonzero coefficient sits in the final position of the block.
// A coefficient of -1 is stored as 16'hFFFE because 16'hFFFF is reserved
// for EOB. When that happens sat_flag is set for the block.
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start, tx_size  begin a block; tx_size (4/8/16/32/64) selects its length
//   coeff_in/_valid/_last/_ready   coefficient input handshake
//   symbol_out, context_idx, symbol_valid, symbol_ready  symbol output handshake
//   busy            not IDLE
//   sat_flag        sticky per block: a -1 coefficient was remapped
//   nz_count        nonzero symbols emitted in the current/last block
//   done            one-cycle pulse at block completion
//
// Optional feature macro: AV2_COEFF_ENC_STATS_EN
//   When it is defined, nz_count is a live counter.
//   When it is undefined, nz_count is tied to 0.
// ---------------------------------------------------------------------------
module av2_coeff_encoder #(
    parameter int MAX_COEFFS  = 4096,
    parameter int MAX_TX_SIZE = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  tx_size,
    input  logic [15:0] coeff_in,
    input  logic        coeff_valid,
    input  logic        coeff_last,
    output logic        coeff_ready,
    output logic [15:0] symbol_out,
    output logic [15:0] context_idx,
    output logic        symbol_valid,
    input  logic        symbol_ready,
    output logic        busy,
    output logic        sat_flag,
    output logic [12:0] nz_count,
    output logic        done
);
    localparam int AW = $clog2(MAX_COEFFS);
    localparam int CW = AW + 1;
    // The largest block is bounded by the buffer depth.
    localparam int MAX_BLK = (MAX_TX_SIZE * MAX_TX_SIZE < MAX_COEFFS) ?
                             MAX_TX_SIZE * MAX_TX_SIZE : MAX_COEFFS;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EMIT = 3'd2,
        S_EOB  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state, state_nx;
    logic [15:0]     mem [MAX_COEFFS];
    logic [CW-1:0]   max_coeffs, max_dec, wptr;
    logic [AW-1:0]   last_nz, eidx, eidx_inc;
    logic            has_nz, has_nz_nx;
    logic            ld_fire, ld_final, sym_fire, em_fire, full_blk;
    logic [15:0]     wdata, first_sym;

    always_comb begin
        max_dec = CW'(256);
        case (tx_size)
            6'd4:    max_dec = CW'(16);
            6'd8:    max_dec = CW'(64);
            6'd16:   max_dec = CW'(256);
            6'd32:   max_dec = CW'(1024);
            6'd64:   max_dec = CW'(MAX_BLK);
            default: max_dec = CW'(256);
        endcase
    end

    assign ld_fire   = (state == S_LOAD) && coeff_valid && coeff_ready;
    // The block ends at coeff_last or when the buffer reaches the block size.
    // At the final slot, coeff_last makes no difference.
    assign ld_final  = coeff_last || (wptr == max_coeffs - CW'(1));
    assign wdata     = (coeff_in == 16'hFFFF) ? 16'hFFFE : coeff_in;
    assign has_nz_nx = has_nz || (coeff_in != 16'd0);
    // A one-coefficient block has its first symbol still in flight.
    // Forward it from the input in that case.
    assign first_sym = (wptr == CW'(0)) ? wdata : mem[0];
    assign sym_fire  = symbol_valid && symbol_ready;
    assign em_fire   = (state == S_EMIT) && sym_fire;
    assign eidx_inc  = eidx + AW'(1);
    assign full_blk  = ({1'b0, last_nz} == max_coeffs - CW'(1));
    assign busy      = (state != S_IDLE);

    // The buffer is not reset. Stale contents are never read, because the
    // emit phase only reads positions that were written in this block.
    always_ff @(posedge clk) begin
        if (ld_fire) mem[wptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_LOAD;
            S_LOAD: if (ld_fire && ld_final) state_nx = has_nz_nx ? S_EMIT : S_EOB;
            S_EMIT: if (em_fire && eidx == last_nz) state_nx = full_blk ? S_DONE : S_EOB;
            S_EOB:  if (sym_fire) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_coeffs   <= '0;
            wptr         <= '0;
            last_nz      <= '0;
            has_nz       <= 1'b0;
            eidx         <= '0;
            coeff_ready  <= 1'b0;
            symbol_out   <= '0;
            context_idx  <= '0;
            symbol_valid <= 1'b0;
            sat_flag     <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        max_coeffs  <= max_dec;
                        coeff_ready <= 1'b1;
                        sat_flag    <= 1'b0;
                        has_nz      <= 1'b0;
                        wptr        <= '0;
                        last_nz     <= '0;
                    end
                end
                S_LOAD: begin
                    if (ld_fire) begin
                        wptr <= wptr + CW'(1);
                        if (coeff_in != 16'd0) begin
                            last_nz <= wptr[AW-1:0];
                            has_nz  <= 1'b1;
                        end
                        if (coeff_in == 16'hFFFF) sat_flag <= 1'b1;
                        if (ld_final) begin
                            coeff_ready  <= 1'b0;
                            symbol_valid <= 1'b1;
                            eidx         <= '0;
                            context_idx  <= '0;
                            // If the block is all zero, go straight to EOB at position 0.
                            symbol_out   <= has_nz_nx ? first_sym : 16'hFFFF;
                        end
                    end
                end
                S_EMIT: begin
                    if (sym_fire) begin
                        if (eidx == last_nz) begin
                            if (full_blk) begin
                                symbol_valid <= 1'b0;
                                symbol_out   <= '0;
                                context_idx  <= '0;
                                done         <= 1'b1;
                            end else begin
                                symbol_out  <= 16'hFFFF;
                                context_idx <= 16'(last_nz) + 16'd1;
                            end
                        end else begin
                            eidx        <= eidx_inc;
                            symbol_out  <= mem[eidx_inc];
                            context_idx <= 16'(eidx_inc);
                        end
                    end
                end
                S_EOB: begin
                    if (sym_fire) begin
                        symbol_valid <= 1'b0;
                        symbol_out   <= '0;
                        context_idx  <= '0;
                        done         <= 1'b1;
                    end
                end
                S_DONE: done <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef AV2_COEFF_ENC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          nz_count <= '0;
        else if (state == S_IDLE && start)   nz_count <= '0;
        else if (em_fire && symbol_out != 16'd0) nz_count <= nz_count + 13'd1;
    end
`else
    assign nz_count = '0;
`endif

endmodule

// File: doc/av2_coeff_encoder.md
Name: av2_coeff_encoder

Overview:
Transmit-side counterpart of the AV2 coefficient decoder. Accepts one transform block of quantized coefficients in scan order and buffers them. Emits them as a symbol stream toward the entropy encoder: the values at positions 0 through the last nonzero position, then the EOB symbol 16'hFFFF when the block is not full. Its symbol output plugs directly into the decoder-side symbol interface used in loopback benches.

Parameters:
MAX_COEFFS, 4096, depth of internal coefficient buffer (entries of 16 bits).
MAX_TX_SIZE, 64, largest supported transform edge; informational, no logic beyond tx_size decode.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a block; sampled only in IDLE
tx_size  input  6  transform edge, sampled with start: 4→16, 8→64, 16→256, 32→1024, 64→4096 coeffs, other→256
coeff_in  input  16  signed coefficient, scan order
coeff_valid  input  1  coeff_in valid
coeff_last  input  1  qualifies final coefficient of block (with coeff_valid)
coeff_ready  output  1  encoder accepts coeff_in
symbol_out  output  16  symbol to entropy encoder
context_idx  output  16  scan position of current symbol; EOB carries position count
symbol_valid  output  1  symbol_out valid
symbol_ready  input  1  entropy encoder accepts symbol
busy  output  1  high in any state except IDLE
sat_flag  output  1  sticky per block: a coefficient of -1 was remapped
nz_count  output  13  nonzero coefficients emitted (see Optional Feature)
done  output  1  one-cycle pulse at block completion

Behaviour:
- Reset (async, any state, including mid-block): state IDLE; all outputs 0; write pointer, last_nz, has_nz and counters cleared. Buffer contents are not cleared.
- States: IDLE, LOAD, EMIT, EOB, DONE (3-bit encoding).
- IDLE: start=1 latches max_coeffs from tx_size → LOAD next cycle. coeff_ready goes 1 in that same registered update. sat_flag, has_nz, wptr and last_nz clear.
- LOAD: coeff_ready=1. Each coeff_valid&coeff_ready handshake:
  - write coeffs[wptr] and increment wptr.
  - If coeff_in≠0, set last_nz=wptr and has_nz=1.
  - If coeff_in=16'hFFFF (-1), store 16'hFFFE and set sat_flag. 16'hFFFF is reserved for EOB.
- LOAD exits on a handshake with coeff_last=1, or on the handshake at wptr=max_coeffs-1 (coeff_last ignored there). coeff_ready drops the same edge; next state EMIT if has_nz, else EOB.
- Any coefficient offered after LOAD ends is not accepted (coeff_ready=0).
- EMIT: symbol_valid=1, symbol_out=coeffs[eidx], context_idx=eidx, starting at eidx=0.
  - On symbol_valid&symbol_ready, advance eidx. symbol_out/context_idx stay stable while symbol_ready=0.
  - After the handshake at eidx=last_nz: if last_nz=max_coeffs-1, go to DONE (full block, no EOB); else go to EOB.
- EOB: symbol_out=16'hFFFF, context_idx=last_nz+1 (0 if no nonzero), symbol_valid=1. Handshake → DONE.
- DONE: done=1 for exactly one cycle; symbol_valid=0; → IDLE. busy=0 from the next cycle; start accepted from then on.
- Symbol outputs are registered: first symbol_valid appears the cycle after the final LOAD handshake. Back-to-back symbols are sent one per cycle when symbol_ready is held 1.
- Trailing zeros after last_nz are never emitted. An all-zero block emits only the EOB symbol.
- start outside IDLE is ignored. tx_size is not resampled mid-block.

Optional Feature:
AV2_COEFF_ENC_STATS_EN:
- Defined: nz_count clears on start and increments on every EMIT handshake whose symbol_out≠0. It holds its value after DONE until the next start.
- Undefined: nz_count is tied to 0 and the counter logic is absent.
- All other behaviour is identical in both builds.

Test Plan:
- 4x4: start, tx_size=4; coeffs 5,0,-3 then thirteen 0s with coeff_last on the 16th → symbols 5,0,16'hFFFD,16'hFFFF with context_idx 0,1,2,3. done pulses once; nz_count=2 with STATS_EN.
- All-zero 4x4 → single symbol 16'hFFFF with context_idx=0, then done.
- Full 4x4 with coeff 16 at position 15, others 1 → 16 symbols, no EOB. coeff_ready drops after the 16th handshake without coeff_last.
- Backpressure: symbol_ready toggled 1,0,0,1,… → no symbol duplicated or skipped; symbol_out stable while stalled.
- coeff -1 at position 0 of an 8x8, then coeff_last → symbol 16'hFFFE then 16'hFFFF; sat_flag=1. The next block's start clears it.
- Reset asserted mid-EMIT → same cycle symbol_valid=0, busy=0. After release, a new start encodes a fresh 4x4 correctly.
